// File: rtl/cmd_issue_queue.sv
// Command FIFO feeding the register/ALU controller: one-cycle syscall strobe per command,
// followed by a hold window (longer for CAS) during which the command bus stays stable.
module cmd_issue_queue #(
    parameter int DEPTH    = 8,
    parameter int HOLD     = 2,
    parameter int CAS_HOLD = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [11:0]              cmd_in,
    input  logic                     cmd_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     ready,
    output logic [11:0]              command,
    output logic                     syscall,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              issued,
    output logic                     overflow,
    output logic [1:0]               dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(CAS_HOLD + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD);
    localparam logic [HW-1:0] CAS_LD   = HW'(CAS_HOLD);
    localparam logic [HW-1:0] HOLD_END = HW'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PULSE = 2'd1, S_HOLD = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [11:0]       mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [11:0]       command_q, command_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [15:0]       issued_q, issued_d;
    logic              overflow_q, overflow_d;
    logic              full, push, pop;

    // Upstream handshake: a command is accepted on a rising edge where cmd_valid && in_ready
    // (and no flush); downstream, a command is taken from the FIFO only when the FSM is idle and
    // the controller's ready is high, and is then announced by a single-cycle syscall.
    assign full     = (count_q == FULL_CNT);
    assign push     = cmd_valid && !full && !flush;
    assign pop      = (state_q == S_IDLE) && (count_q != '0) && ready;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (cmd_valid && full && !flush);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        command_d = command_q;
        hold_d    = hold_q;
        issued_d  = issued_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    command_d = mem_q[rptr_q];
                    state_d   = S_PULSE;
                end
            end
            S_PULSE: begin
                hold_d  = (command_q[11:9] == 3'b111) ? CAS_LD : HOLD_LD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // The final hold cycle stretches until the controller is ready again.
                if (hold_q == HOLD_END) begin
                    if (ready) begin
                        state_d  = S_IDLE;
                        issued_d = issued_q + 16'd1;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            command_q  <= 12'h000;
            hold_q     <= '0;
            issued_q   <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            command_q  <= command_d;
            hold_q     <= hold_d;
            issued_q   <= issued_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wptr_q] <= cmd_in;
    end

    assign in_ready  = !full;
    assign command   = command_q;
    assign syscall   = (state_q == S_PULSE);
    assign busy      = (state_q != S_IDLE);
    assign count     = count_q;
    assign issued    = issued_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;
endmodule
